// File: rtl/speaker_arbiter.sv
// Speaker arbiter: grants the I2S path to music or sound effects (SFX wins),
// synthesises a square tone per source and inserts muted gaps on every switch.
module speaker_arbiter #(
    parameter int SAMPLE_DIV = 512,
    parameter int SFX_LEN    = 2048,
    parameter int GAP_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        music_req,
    input  logic [21:0] music_half,
    input  logic [2:0]  music_vol,
    input  logic        sfx_req,
    input  logic [21:0] sfx_half,
    input  logic [2:0]  sfx_vol,
    output logic        sfx_ack,
    output logic        sfx_busy,
    output logic        music_grant,
    output logic        sample_tick,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(SFX_LEN + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] PLAY_LAST = PW'(SFX_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUSIC,
        GAP,
        SFX
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] play_cnt;
    logic [GW-1:0] gap_cnt;
    logic [21:0]   tcnt;
    logic          phase;
    logic          sfx_pend;
    logic [21:0]   sfx_half_q;
    logic [2:0]    sfx_vol_q;

    logic [21:0]   cur_half;
    logic [2:0]    cur_vol;
    logic [15:0]   amp;
    logic [15:0]   sample;
    logic          tone_on;
    logic          tone_wrap;
    logic          enter_sfx;
    logic          enter_tone;

    assign sample_tick = (cnt == CNT_LAST);
    assign audio_right = audio_left;

    assign cur_half  = (state == SFX) ? sfx_half_q : music_half;
    assign cur_vol   = (state == SFX) ? sfx_vol_q : music_vol;
    assign amp       = {1'b0, cur_vol, 12'h000};
    assign tone_on   = (state == MUSIC || state == SFX) &&
                       cur_vol != 3'd0 && cur_half != 22'd0;
    // >= rather than == so a lowered live music_half cannot overshoot
    assign tone_wrap = tcnt >= (cur_half - 22'd1);
    assign sample    = !tone_on ? 16'h0000 : (phase ? amp : -amp);

    assign enter_sfx  = (nxt == SFX) && (state != SFX);
    assign enter_tone = (nxt != state) && (nxt == MUSIC || nxt == SFX);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (sfx_pend || sfx_req)
                    nxt = SFX;
                else if (music_req)
                    nxt = MUSIC;
            end
            MUSIC: begin
                if (sfx_req || sfx_pend)
                    nxt = GAP;
                else if (!music_req)
                    nxt = IDLE;
            end
            SFX: begin
                if (sample_tick && play_cnt == PLAY_LAST)
                    nxt = GAP;
            end
            GAP: begin
                if (sample_tick && gap_cnt == GAP_LAST) begin
                    if (sfx_pend)
                        nxt = SFX;
                    else if (music_req)
                        nxt = MUSIC;
                    else
                        nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            play_cnt    <= '0;
            gap_cnt     <= '0;
            tcnt        <= '0;
            phase       <= 1'b0;
            sfx_pend    <= 1'b0;
            sfx_half_q  <= '0;
            sfx_vol_q   <= '0;
            sfx_ack     <= 1'b0;
            sfx_busy    <= 1'b0;
            music_grant <= 1'b0;
            audio_left  <= '0;
        end else begin
            state       <= nxt;
            sfx_ack     <= enter_sfx;
            sfx_busy    <= (nxt == SFX);
            music_grant <= (nxt == MUSIC);

            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

            if (enter_sfx)
                sfx_pend <= 1'b0;
            else if (sfx_req && state != SFX)
                sfx_pend <= 1'b1;

            if (enter_sfx) begin
                sfx_half_q <= sfx_half;
                sfx_vol_q  <= sfx_vol;
                play_cnt   <= '0;
            end else if (state == SFX && sample_tick) begin
                play_cnt <= play_cnt + PW'(1);
            end

            if (nxt == GAP && state != GAP)
                gap_cnt <= '0;
            else if (state == GAP && sample_tick)
                gap_cnt <= gap_cnt + GW'(1);

            if (enter_tone) begin
                tcnt  <= '0;
                phase <= 1'b0;
            end else if (state == MUSIC || state == SFX) begin
                if (tone_wrap) begin
                    tcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    tcnt <= tcnt + 22'd1;
                end
            end

            // audio reflects the state and phase seen at the tick edge
            if (sample_tick)
                audio_left <= sample;
        end
    end

endmodule

// File: tb/tb_speaker_arbiter.sv
// Bench for speaker_arbiter: directed scenarios plus random traffic,
// checked every cycle against an arithmetic reference model.
module tb_speaker_arbiter;

    localparam int DIV  = 512;
    localparam int SLEN = 8;
    localparam int GLEN = 4;
    localparam int S_IDLE  = 0;
    localparam int S_MUSIC = 1;
    localparam int S_GAP   = 2;
    localparam int S_SFX   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        music_req;
    logic [21:0] music_half;
    logic [2:0]  music_vol;
    logic        sfx_req;
    logic [21:0] sfx_half;
    logic [2:0]  sfx_vol;
    logic        sfx_ack;
    logic        sfx_busy;
    logic        music_grant;
    logic        sample_tick;
    logic [15:0] audio_left;
    logic [15:0] audio_right;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;

    int          m_st;
    bit          m_pend;
    int          m_ticks;
    int          m_te;
    int          m_edges;
    int          m_lh;
    int          m_lv;
    logic [15:0] m_audio;
    bit          m_ack;

    speaker_arbiter #(
        .SAMPLE_DIV(DIV),
        .SFX_LEN(SLEN),
        .GAP_LEN(GLEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .music_req(music_req),
        .music_half(music_half),
        .music_vol(music_vol),
        .sfx_req(sfx_req),
        .sfx_half(sfx_half),
        .sfx_vol(sfx_vol),
        .sfx_ack(sfx_ack),
        .sfx_busy(sfx_busy),
        .music_grant(music_grant),
        .sample_tick(sample_tick),
        .audio_left(audio_left),
        .audio_right(audio_right)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = S_IDLE;
        m_pend  = 0;
        m_ticks = 0;
        m_te    = 0;
        m_edges = 0;
        m_lh    = 0;
        m_lv    = 0;
        m_audio = 16'h0;
        m_ack   = 0;
    endtask

    // Square wave: phase flips every `half` clocks after tone entry.
    function automatic logic [15:0] model_sample();
        int h;
        int v;
        if (m_st == S_MUSIC) begin
            h = int'(music_half);
            v = int'(music_vol);
        end else if (m_st == S_SFX) begin
            h = m_lh;
            v = m_lv;
        end else begin
            return 16'h0;
        end
        if (h == 0 || v == 0)
            return 16'h0;
        if ((m_te / h) % 2 == 1)
            return 16'(v * 4096);
        return 16'(65536 - v * 4096);
    endfunction

    task automatic model_edge();
        bit tick;
        int nx;
        tick = (m_edges % DIV) == DIV - 1;
        if (tick)
            m_audio = model_sample();
        nx = m_st;
        case (m_st)
            S_IDLE:
                if (m_pend || sfx_req) nx = S_SFX;
                else if (music_req) nx = S_MUSIC;
            S_MUSIC:
                if (sfx_req || m_pend) nx = S_GAP;
                else if (!music_req) nx = S_IDLE;
            S_SFX:
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == SLEN) nx = S_GAP;
                end
            default:
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == GLEN)
                        nx = m_pend ? S_SFX : (music_req ? S_MUSIC : S_IDLE);
                end
        endcase
        m_ack = (nx == S_SFX) && (m_st != S_SFX);
        if (sfx_req && m_st != S_SFX)
            m_pend = 1;
        if (m_ack) begin
            m_pend = 0;
            m_lh = int'(sfx_half);
            m_lv = int'(sfx_vol);
        end
        if (nx != m_st) begin
            m_ticks = 0;
            m_te = 0;
        end else begin
            m_te++;
        end
        m_st = nx;
        m_edges++;
    endtask

    task automatic check_now();
        chk("tick", sample_tick, (m_edges % DIV) == DIV - 1);
        chk("audio_l", audio_left, m_audio);
        chk("audio_r", audio_right, m_audio);
        chk("ack", sfx_ack, m_ack);
        chk("busy", sfx_busy, m_st == S_SFX);
        chk("grant", music_grant, m_st == S_MUSIC);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n)
                model_edge();
            #1;
            if (sfx_ack)
                ack_seen++;
            if (bad < 30)
                check_now();
        end
    endtask

    task automatic wait_state(int s, int limit, string tag);
        int n = 0;
        while (m_st != s && n < limit) begin
            step(1);
            n++;
        end
        chk(tag, {sfx_busy, music_grant},
            {s == S_SFX, s == S_MUSIC});
    endtask

    initial begin
        rst_n = 1'b0;
        music_req = 0;
        music_half = '0;
        music_vol = '0;
        sfx_req = 0;
        sfx_half = '0;
        sfx_vol = '0;
        model_reset();
        step(10);
        rst_n = 1'b1;
        step(1100);

        music_half = 22'd1024;
        music_vol = 3'd7;
        music_req = 1;
        step(1);
        chk("grant_next", music_grant, 1);
        step(3 * 2048);
        music_req = 0;
        step(600);

        music_req = 1;
        step(1000);
        sfx_half = 22'd512;
        sfx_vol = 3'd3;
        sfx_req = 1;
        ack_seen = 0;
        step(1);
        sfx_req = 0;
        wait_state(S_SFX, GLEN * DIV + 600, "enter_sfx1");
        step(4 * DIV);
        sfx_req = 1;
        step(1);
        sfx_req = 0;
        wait_state(S_GAP, SLEN * DIV, "sfx1_end");
        chk("acks_one", ack_seen, 1);
        step(700);
        sfx_req = 1;
        step(1);
        sfx_req = 0;
        wait_state(S_SFX, GLEN * DIV, "sfx2_after_gap");
        chk("acks_two", ack_seen, 2);
        wait_state(S_GAP, SLEN * DIV + 10, "sfx2_end");
        wait_state(S_MUSIC, GLEN * DIV + 10, "music_resume");
        step(1500);
        music_req = 0;
        wait_state(S_IDLE, 4, "music_drop");
        step(600);

        music_req = 1;
        sfx_req = 1;
        sfx_half = 22'd100;
        sfx_vol = 3'd5;
        step(1);
        chk("tie_sfx", sfx_busy, 1);
        sfx_req = 0;
        wait_state(S_MUSIC, (SLEN + GLEN + 2) * DIV, "tie_music");
        music_vol = 3'd0;
        step(1100);
        music_vol = 3'd7;
        music_half = 22'd0;
        step(1100);
        music_req = 0;
        step(2);
        music_half = 22'd700;

        for (int i = 0; i < 40; i++) begin
            music_req = 1'($urandom_range(0, 1));
            sfx_req = ($urandom_range(0, 3) == 0);
            sfx_half = 22'($urandom_range(0, 600));
            sfx_vol = 3'($urandom_range(0, 7));
            music_vol = 3'($urandom_range(0, 7));
            if (m_st != S_MUSIC)
                music_half = 22'($urandom_range(0, 1500));
            step(1);
            sfx_req = 0;
            step($urandom_range(1, 800));
        end

        music_req = 0;
        wait_state(S_IDLE, 30 * DIV, "drain_idle");
        sfx_half = 22'd300;
        sfx_vol = 3'd5;
        sfx_req = 1;
        step(1);
        sfx_req = 0;
        step(600);
        chk("pre_reset_audio", audio_left != 16'h0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_audio", audio_left, 16'h0);
        chk("rst_busy", sfx_busy, 0);
        chk("rst_tick", sample_tick, 0);
        step(3);
        rst_n = 1'b1;
        step(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speaker_arbiter.md
# speaker_arbiter

Two-source audio arbiter and tone sequencer placed directly upstream of the I2S speaker serializer. It grants the speaker to a background-music requester or a sound-effect requester, with sound effects taking priority. It synthesises a square-wave tone for the granted source and presents one 16-bit sample per sample period on both channels. Every source switch is separated by a muted gap to suppress clicks.

## Interface
- SAMPLE_DIV, 512: clk cycles per audio sample; must equal the serializer LRCK period.
- SFX_LEN, 2048: samples a granted sound effect plays before release.
- GAP_LEN, 4: muted samples inserted at every source switch.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- music_req  in  1  level; music wants the speaker while high.
- music_half  in  22  music tone half-period in clk cycles; 0 means silence. Sampled live.
- music_vol  in  3  music volume, 0..7.
- sfx_req  in  1  pulse or level; requests one sound-effect play.
- sfx_half  in  22  sound-effect half-period; latched at grant.
- sfx_vol  in  3  sound-effect volume; latched at grant.
- sfx_ack  out  1  one-cycle pulse on SFX entry.
- sfx_busy  out  1  high while the state is SFX.
- music_grant  out  1  high while the state is MUSIC.
- sample_tick  out  1  high for one cycle per sample period.
- audio_left  out  16  two's-complement sample to the serializer.
- audio_right  out  16  identical to audio_left.

## Operation
- **Sample counter.** Width is clog2(SAMPLE_DIV). It counts 0..SAMPLE_DIV-1 and wraps. sample_tick = (cnt == SAMPLE_DIV-1) and is decoded from the register.
- **States.** IDLE, MUSIC, GAP, SFX. Transitions are evaluated every clk, not only on ticks.
- **sfx_pend flag.** Set on any cycle with sfx_req=1 while not in SFX. Cleared on SFX entry. sfx_req is ignored while in SFX: no restart, no ack.
- **IDLE**
  - sfx_pend or sfx_req goes to SFX (priority).
  - Else music_req goes to MUSIC.
- **MUSIC**
  - sfx_req or sfx_pend goes to GAP.
  - Else music_req=0 goes to IDLE.
- **SFX.** A play counter increments on each tick. When SFX_LEN ticks have elapsed, the state goes to GAP.
- **GAP.** A gap counter increments on each tick. After GAP_LEN ticks:
  - sfx_pend goes to SFX.
  - Else music_req goes to MUSIC.
  - Else go to IDLE.
- **On SFX entry.**
  - Latch sfx_half and sfx_vol.
  - Clear the play counter.
  - Pulse sfx_ack.
- **On MUSIC or SFX entry.** Clear the tone counter (22 bit) and phase.
- **Tone generator**
  - In MUSIC/SFX, the tone counter increments every clk.
  - When tcnt >= half-1, tcnt resets to 0 and phase toggles.
  - The >= compare makes a lowered music_half take effect immediately.
- **Amplitude.** amp = {1'b0, vol, 12'h000}, so the maximum is 0x7000.
  - Sample = phase ? amp : -amp (two's complement).
  - Sample is 0 when vol=0, when half=0, or in IDLE/GAP.
- **Output register.** audio_left and audio_right are loaded only on the edge ending a sample_tick cycle, using the state and phase at that edge.

## Timing
- **Reset values.** All outputs 0. Counters 0, phase 0, sfx_pend 0, state IDLE.
- **Asynchronous reset.** Asserting rst_n mid-operation zeroes everything immediately, including audio.
- **First tick.** After reset release, the first sample_tick occurs in the cycle after the (SAMPLE_DIV-1)th rising edge.
- **Request latency.** A request-driven transition occurs on the first clk edge after the request is sampled.
- **sfx_ack.** High exactly in the first cycle in SFX.
- **Audio latency.** Audio reflects a new state at the first tick after entry, i.e. at most SAMPLE_DIV cycles later.
- **Tone period.** One full tone period equals 2·half clk cycles.
- **SFX duration.** SFX occupancy is exactly SFX_LEN ticks, plus a partial period of 0..SAMPLE_DIV-1 cycles before the first tick.
- **Gap.** A GAP produces at least GAP_LEN zero samples.
- **Simultaneous events**
  - sfx_req and music_req together in IDLE: SFX wins.
  - sfx_req during GAP: recorded in sfx_pend and honoured at GAP exit.
  - music_req dropping during SFX: GAP exits to IDLE.
- **Wrap-around.** The sample counter wraps silently. The play and gap counters must not wrap before their compare, so their width is clog2(SFX_LEN+1) and clog2(GAP_LEN+1) respectively.

## Test plan
- **Reset.** Hold rst_n=0 for 10 cycles, release with no requests. Required: audio 0, grants 0, sample_tick every 512 cycles.
- **Music tone.** music_req=1, music_half=1024, music_vol=7. Required: music_grant high next cycle; samples alternate 0x7000 / 0x9000 with a 2048-cycle period; music_req=0 returns to IDLE with audio 0 at the next tick.
- **Preemption** (SFX_LEN=8, GAP_LEN=4). During music, pulse sfx_req with sfx_half=512, sfx_vol=3. Required:
  - GAP with 4 zero samples.
  - sfx_ack single pulse, then 8 samples of ±0x3000.
  - GAP, then music resumes.
- **Ignored retrigger.** Pulse sfx_req again mid-SFX. Required: no second ack, and SFX still ends after 8 ticks.
- **Retrigger during gap.** Pulse sfx_req during the post-SFX GAP. Required: second SFX runs after the gap, not music.
- **Edge cases.** Tie in IDLE goes to SFX first. music_vol=0 or music_half=0 gives zero audio while music_grant=1. rst_n pulse mid-SFX zeroes audio asynchronously and returns to IDLE.
